hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- ID-stage hazard detector and stall/flush generator for the 5-stage MIPS pipeline; it generates the stalls that the ID-stage branch operand forwarding cannot cover.
- Keeps its own shadow copy of the EX and MEM writer information (reg-write, load, destination). It drives the pipeline enables and IF/ID flush, and exports the EX/MEM writer fields to the forwarding logic.
- Also counts stall, flush and freeze cycles for performance debug.

Parameters:
CNT_W, 16, width of each saturating performance counter
REG_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_reg_write  in  1  ID instruction writes a register
id_mem_read  in  1  ID instruction is a load
id_wr_addr  in  REG_W  ID destination register
id_rs  in  REG_W  ID source rs
id_rt  in  REG_W  ID source rt
id_use_rs  in  1  ID reads rs
id_use_rt  in  1  ID reads rt
id_branch  in  1  ID instruction is a branch (compared in ID)
branch_taken  in  1  ID comparator result, qualified by id_branch
mem_busy  in  1  data memory not ready; freezes the whole pipeline
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID at next edge
idex_bubble  out  1  load NOP into ID/EX at next edge
r_writeexe  out  1  shadow EX reg-write
wr_addrexe  out  REG_W  shadow EX destination
r_writemem  out  1  shadow MEM reg-write
wr_addrmem  out  REG_W  shadow MEM destination
stall_cnt  out  CNT_W  hazard-stall cycles
flush_cnt  out  CNT_W  flush cycles
freeze_cnt  out  CNT_W  mem_busy cycles

Behaviour:
- Shadow state: ex_{rw,ld,addr} and mem_{rw,addr}. Reset clears all of it to 0 (async). All counters also reset to 0.
- match(a) = a!=0 & ((id_use_rs & id_rs==a) | (id_use_rt & id_rt==a)). Register 0 never causes a hazard.
- Hazard conditions (only when id_valid=1; id_valid=0 means no hazard):
  - Load-use: ex_ld & match(ex_addr).
  - Branch-load-MEM: id_branch & mem_ld_r & match(mem_addr). mem_ld_r is the ex_ld value registered into MEM. Load data is not forwardable to ID until WB.
  - Branch after an ALU writer in EX or MEM: no hazard, because the forwarding path covers it.
- hazard = load-use | branch-load-MEM.
- Net effect for a branch depending on a load directly ahead: exactly 2 stall cycles. For a non-branch consumer: 1 stall cycle.
- Output priority, evaluated combinationally each cycle:
  1. rst=1: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
  2. mem_busy=1 (freeze): pc_en=0, ifid_en=0, idex_bubble=0, ifid_flush=0. Shadow state holds. freeze_cnt increments.
  3. hazard: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0. At the edge, EX shadow gets a bubble (rw=0, ld=0, addr=0). stall_cnt increments.
  4. id_valid & id_branch & branch_taken: pc_en=1, ifid_en=1, ifid_flush=1. Shadow advances. flush_cnt increments.
  5. Otherwise: pc_en=1, ifid_en=1, idex_bubble=0, ifid_flush=0.
- Shadow advance (cases 3–5):
  - EX shadow loads the ID fields, with rw and ld gated by id_valid. In case 3 it loads the bubble instead.
  - mem_rw, mem_addr and mem_ld_r load from EX.
- A taken branch that is also hazarded is not flushed in that cycle. The flush happens in the cycle its hazard clears.
- Counters saturate at all-ones and never wrap.
- r_writeexe, wr_addrexe, r_writemem and wr_addrmem are driven directly from the shadow registers, giving zero-latency visibility.
- Reset asserted mid-stall: all state clears immediately. The first cycle after release is case 5 unless the inputs create a new hazard.

Decomposition:
- Shared package mips_pkg: REG_W, the REG_ZERO constant, and the opcode/funct constants used by the decoder to build id_use_rs, id_use_rt and id_mem_read.
- Sub-module sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated three times.
- Hazard compare and shadow registers stay in the top module.

Test Plan:
- lw $2 then add $3,$2,$4 -> one cycle with pc_en=0, idex_bubble=1; then normal flow; stall_cnt=1.
- lw $2 then beq $2,$5 -> two consecutive stall cycles, then branch proceeds; with branch_taken=1, ifid_flush=1 on the third cycle; stall_cnt=2, flush_cnt=1.
- add $2 then beq $2,$0 -> no stall; r_writeexe=1, wr_addrexe=2 in the branch's ID cycle.
- lw $0 then add $3,$0,$0 -> no stall.
- mem_busy=1 for 3 cycles during a load-use stall -> pc_en=0, idex_bubble=0, shadow unchanged, freeze_cnt=3; the stall completes after release.
- Force stall_cnt to all-ones via long hazard run at CNT_W=4 -> holds at 15. Assert rst mid-stall -> shadow outputs 0 and counters 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants: register width, $zero, opcode/funct codes
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Opcodes the decoder uses to build id_use_rs, id_use_rt and id_mem_read
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID-stage decode inputs and pipeline control outputs of the stall unit
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [REG_W-1:0] id_wr_addr;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch;
    logic             branch_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             r_writeexe;
    logic [REG_W-1:0] wr_addrexe;
    logic             r_writemem;
    logic [REG_W-1:0] wr_addrmem;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;

    // Pipeline side: presents the decoded ID instruction, consumes the controls
    modport master (
        output id_valid, id_reg_write, id_mem_read, id_wr_addr, id_rs, id_rt,
               id_use_rs, id_use_rt, id_branch, branch_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, r_writeexe, wr_addrexe,
               r_writemem, wr_addrmem, stall_cnt, flush_cnt, freeze_cnt
    );

    // Stall unit side
    modport slave (
        input  id_valid, id_reg_write, id_mem_read, id_wr_addr, id_rs, id_rt,
               id_use_rs, id_use_rt, id_branch, branch_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_bubble, r_writeexe, wr_addrexe,
               r_writemem, wr_addrmem, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - performance counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualifying cycles, holding once the maximum is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage load hazard detector, stall/flush generator and shadow EX/MEM writer state
module hazard_stall_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = mips_pkg::REG_W
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave hs
);

    localparam logic [REG_W-1:0] ZERO_ADDR = REG_W'(REG_ZERO);

    logic             ex_rw;
    logic             ex_ld;
    logic [REG_W-1:0] ex_addr;
    logic             mem_rw;
    logic             mem_ld_r;
    logic [REG_W-1:0] mem_addr;

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic br_load_mem;
    logic hazard;
    logic take_flush;

    logic pc_en_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_bubble_c;

    // A source operand only conflicts with a real (non-$zero) destination it actually reads
    assign match_ex  = (ex_addr != ZERO_ADDR) &&
                       ((hs.id_use_rs && (hs.id_rs == ex_addr)) ||
                        (hs.id_use_rt && (hs.id_rt == ex_addr)));
    assign match_mem = (mem_addr != ZERO_ADDR) &&
                       ((hs.id_use_rs && (hs.id_rs == mem_addr)) ||
                        (hs.id_use_rt && (hs.id_rt == mem_addr)));

    // Load data reaches ID only from WB, so a branch waits out a load still in MEM;
    // ALU results in EX/MEM are covered by the ID-stage forwarding path
    assign load_use    = ex_ld && match_ex;
    assign br_load_mem = hs.id_branch && mem_ld_r && match_mem;
    assign hazard      = hs.id_valid && (load_use || br_load_mem);
    assign take_flush  = hs.id_valid && hs.id_branch && hs.branch_taken;

    // Pipeline controls by priority: reset, memory freeze, hazard stall, taken-branch flush, normal
    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        if (rst) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (hs.mem_busy) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
        end else if (hazard) begin
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_bubble_c = 1'b1;
        end else if (take_flush) begin
            ifid_flush_c = 1'b1;
        end
    end

    // Shadow EX/MEM writer state: hold on freeze, insert a bubble into EX on a hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rw    <= 1'b0;
            ex_ld    <= 1'b0;
            ex_addr  <= '0;
            mem_rw   <= 1'b0;
            mem_ld_r <= 1'b0;
            mem_addr <= '0;
        end else if (!hs.mem_busy) begin
            mem_rw   <= ex_rw;
            mem_ld_r <= ex_ld;
            mem_addr <= ex_addr;
            if (hazard) begin
                ex_rw   <= 1'b0;
                ex_ld   <= 1'b0;
                ex_addr <= '0;
            end else begin
                ex_rw   <= hs.id_valid && hs.id_reg_write;
                ex_ld   <= hs.id_valid && hs.id_mem_read;
                ex_addr <= hs.id_wr_addr;
            end
        end
    end

    assign hs.pc_en       = pc_en_c;
    assign hs.ifid_en     = ifid_en_c;
    assign hs.ifid_flush  = ifid_flush_c;
    assign hs.idex_bubble = idex_bubble_c;
    assign hs.r_writeexe  = ex_rw;
    assign hs.wr_addrexe  = ex_addr;
    assign hs.r_writemem  = mem_rw;
    assign hs.wr_addrmem  = mem_addr;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!hs.mem_busy && hazard),
        .count (hs.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!hs.mem_busy && !hazard && take_flush),
        .count (hs.flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hs.mem_busy),
        .count (hs.freeze_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit against a pipeline-slot reference model
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    hazard_stall_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hs ();

    hazard_stall_unit #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (hs)
    );

    typedef struct {
        logic       valid;
        logic       rw;
        logic       ld;
        logic [4:0] wa;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       br;
        logic       tk;
    } instr_t;

    typedef struct {
        logic       rw;
        logic       ld;
        logic [4:0] addr;
    } slot_t;

    typedef struct {
        int pc_en;
        int ifid_en;
        int ifid_flush;
        int idex_bubble;
        int rwe;
        int wae;
        int rwm;
        int wam;
        int sc;
        int fc;
        int zc;
    } exp_t;

    exp_t  sb[$];
    slot_t ex_s;
    slot_t mem_s;
    int    sc;
    int    fc;
    int    zc;
    int    tests = 0;
    int    fails = 0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit reads(input instr_t i, input logic [4:0] a);
        return (a != 5'd0) && ((i.urs && i.rs == a) || (i.urt && i.rt == a));
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    function automatic instr_t nop();
        instr_t i = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        return i;
    endfunction

    function automatic instr_t lw(input int rd);
        instr_t i = '{1'b1, 1'b1, 1'b1, 5'(rd), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        return i;
    endfunction

    function automatic instr_t add(input int rd, input int rs, input int rt);
        instr_t i = '{1'b1, 1'b1, 1'b0, 5'(rd), 5'(rs), 5'(rt), 1'b1, 1'b1, 1'b0, 1'b0};
        return i;
    endfunction

    function automatic instr_t beq(input int rs, input int rt, input bit tk);
        instr_t i = '{1'b1, 1'b0, 1'b0, 5'd0, 5'(rs), 5'(rt), 1'b1, 1'b1, 1'b1, tk};
        return i;
    endfunction

    // One clock of stimulus: drive, predict, enqueue the prediction, advance the model
    task automatic step(input instr_t i, input bit busy, input bit r, output bit adv);
        bit   hz;
        bit   taken;
        exp_t e;
        hs.id_valid     = i.valid;
        hs.id_reg_write = i.rw;
        hs.id_mem_read  = i.ld;
        hs.id_wr_addr   = i.wa;
        hs.id_rs        = i.rs;
        hs.id_rt        = i.rt;
        hs.id_use_rs    = i.urs;
        hs.id_use_rt    = i.urt;
        hs.id_branch    = i.br;
        hs.branch_taken = i.tk;
        hs.mem_busy     = busy;
        rst             = r;
        if (r) begin
            ex_s  = '{1'b0, 1'b0, 5'd0};
            mem_s = '{1'b0, 1'b0, 5'd0};
            sc = 0;
            fc = 0;
            zc = 0;
        end
        hz = i.valid && ((ex_s.ld && reads(i, ex_s.addr)) ||
                         (i.br && mem_s.ld && reads(i, mem_s.addr)));
        taken = i.valid && i.br && i.tk;
        e.rwe = ex_s.rw;
        e.wae = ex_s.addr;
        e.rwm = mem_s.rw;
        e.wam = mem_s.addr;
        e.sc  = sc;
        e.fc  = fc;
        e.zc  = zc;
        if (r) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1; e.ifid_flush = 0;
        end else if (busy) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 0; e.ifid_flush = 0;
        end else if (hz) begin
            e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1; e.ifid_flush = 0;
        end else begin
            e.pc_en = 1; e.ifid_en = 1; e.idex_bubble = 0; e.ifid_flush = taken ? 1 : 0;
        end
        sb.push_back(e);
        if (!r) begin
            if (busy) begin
                zc = sat(zc);
            end else if (hz) begin
                sc = sat(sc);
                mem_s = ex_s;
                ex_s  = '{1'b0, 1'b0, 5'd0};
            end else begin
                if (taken) fc = sat(fc);
                mem_s = ex_s;
                ex_s  = '{i.valid && i.rw, i.valid && i.ld, i.wa};
            end
        end
        adv = !r && !busy && !hz;
        @(posedge clk);
        #1;
    endtask

    // Present an instruction until ID lets it go, with the first nbusy cycles frozen
    task automatic issue(input instr_t i, input int nbusy);
        bit adv = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(i, k < nbusy, 1'b0, adv);
            if (adv) break;
        end
        if (!adv) begin
            tests++;
            fails++;
            $display("FAIL issue_bound: instruction never left ID within 20 cycles");
        end
    endtask

    task automatic do_reset();
        bit adv;
        step(nop(), 1'b0, 1'b1, adv);
    endtask

    // Monitor: compare every cycle's DUT outputs against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_en",       int'(hs.pc_en),       e.pc_en);
                chk("ifid_en",     int'(hs.ifid_en),     e.ifid_en);
                chk("ifid_flush",  int'(hs.ifid_flush),  e.ifid_flush);
                chk("idex_bubble", int'(hs.idex_bubble), e.idex_bubble);
                chk("r_writeexe",  int'(hs.r_writeexe),  e.rwe);
                chk("wr_addrexe",  int'(hs.wr_addrexe),  e.wae);
                chk("r_writemem",  int'(hs.r_writemem),  e.rwm);
                chk("wr_addrmem",  int'(hs.wr_addrmem),  e.wam);
                chk("stall_cnt",   int'(hs.stall_cnt),   e.sc);
                chk("flush_cnt",   int'(hs.flush_cnt),   e.fc);
                chk("freeze_cnt",  int'(hs.freeze_cnt),  e.zc);
            end
        end
    end

    initial begin
        bit     adv;
        instr_t ri;
        int     nb;

        // load-use, non-branch consumer: one stall
        do_reset();
        issue(lw(2), 0);
        issue(add(3, 2, 4), 0);
        issue(nop(), 0);
        chk("lu_stall_cnt", int'(hs.stall_cnt), 1);

        // load then dependent taken branch: two stalls, then flush
        do_reset();
        issue(lw(2), 0);
        issue(beq(2, 5, 1'b1), 0);
        issue(nop(), 0);
        chk("blu_stall_cnt", int'(hs.stall_cnt), 2);
        chk("blu_flush_cnt", int'(hs.flush_cnt), 1);

        // ALU writer ahead of a branch is forwarded, no stall
        do_reset();
        issue(add(2, 1, 1), 0);
        chk("alu_rw_exe",   int'(hs.r_writeexe), 1);
        chk("alu_addr_exe", int'(hs.wr_addrexe), 2);
        issue(beq(2, 0, 1'b0), 0);
        chk("alu_stall_cnt", int'(hs.stall_cnt), 0);

        // $zero destination never stalls
        do_reset();
        issue(lw(0), 0);
        issue(add(3, 0, 0), 0);
        chk("r0_stall_cnt", int'(hs.stall_cnt), 0);

        // freeze during a load-use stall
        do_reset();
        issue(lw(2), 0);
        issue(add(3, 2, 4), 3);
        chk("frz_freeze_cnt", int'(hs.freeze_cnt), 3);
        chk("frz_stall_cnt",  int'(hs.stall_cnt), 1);

        // saturate stall_cnt, then reset in the middle of a stall
        do_reset();
        for (int n = 0; n < 20; n++) begin
            issue(lw(2), 0);
            issue(add(3, 2, 4), 0);
        end
        chk("sat_stall_cnt", int'(hs.stall_cnt), CMAX);
        issue(lw(2), 0);
        step(add(3, 2, 4), 1'b0, 1'b0, adv);
        step(add(3, 2, 4), 1'b0, 1'b1, adv);
        chk("rst_stall_cnt",  int'(hs.stall_cnt), 0);
        chk("rst_r_writeexe", int'(hs.r_writeexe), 0);
        chk("rst_wr_addrmem", int'(hs.wr_addrmem), 0);
        issue(add(3, 2, 4), 0);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            ri.valid = ($urandom_range(0, 7) != 0);
            ri.rw    = 1'(($urandom_range(0, 3) != 0));
            ri.ld    = 1'(($urandom_range(0, 2) == 0));
            ri.wa    = 5'($urandom_range(0, 3));
            ri.rs    = 5'($urandom_range(0, 3));
            ri.rt    = 5'($urandom_range(0, 3));
            ri.urs   = 1'($urandom_range(0, 1));
            ri.urt   = 1'($urandom_range(0, 1));
            ri.br    = 1'(($urandom_range(0, 2) == 0));
            ri.tk    = 1'($urandom_range(0, 1));
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 59) == 0) begin
                step(ri, 1'b0, 1'b1, adv);
            end
            issue(ri, nb);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
